// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants, funct3 codes and state encodings for div_unit
package div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_END  = 2'd2
  } state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring RV32M divider; optional DIV_EARLY_OUT_EN skips CALC
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [5:0]        r_cnt;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_dvd;
  logic [4:0]        r_rd;
  logic              r_sel_rem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic              r_ready;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_accept;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_dz;
  logic              w_early;
  logic [XLEN+1:0]   w_shift;
  logic              w_ge;
  logic [XLEN:0]     w_sub;
  logic [XLEN-1:0]   w_res_q;
  logic [XLEN-1:0]   w_res_r;

  assign w_accept = (r_state == ST_IDLE) && start_i && op_i[2];
  assign w_a_neg  = ~op_i[0] & dividend_i[XLEN-1];
  assign w_b_neg  = ~op_i[0] & divisor_i[XLEN-1];
  assign w_a_mag  = negate_if(w_a_neg, dividend_i);
  assign w_b_mag  = negate_if(w_b_neg, divisor_i);
  assign w_dz     = (divisor_i == ZERO_WORD);

`ifdef DIV_EARLY_OUT_EN
  // Nothing to iterate when the divisor is zero or already exceeds the dividend.
  assign w_early = w_dz || (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, subtract the divisor if it fits.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {2'b00, r_dvs});
  assign w_sub   = w_shift[XLEN:0] - {1'b0, r_dvs};

  // Final results; divide-by-zero follows the RISC-V rule and bypasses the sign fix.
  assign w_res_q = r_dz ? '1 : negate_if(r_neg_q, r_quo);
  assign w_res_r = r_dz ? r_dvd : negate_if(r_neg_r, r_rem[XLEN-1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_early ? ST_END : ST_CALC;
      ST_CALC: if (r_cnt == 6'(XLEN-1)) w_next = ST_END;
      ST_END:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic: hold the pipeline from the accept cycle through the last CALC cycle.
  always_comb begin
    busy_o = w_accept || (r_state == ST_CALC);
  end

  // Datapath: operand capture, iteration, and result/pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_dvd     <= '0;
      r_rd      <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_dvs     <= w_b_mag;
            r_dvd     <= dividend_i;
            r_rd      <= rd_addr_i;
            r_sel_rem <= op_i[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_dz      <= w_dz;
            if (w_early) begin
              r_quo <= '0;
              r_rem <= {1'b0, w_a_mag};
            end else begin
              r_quo <= w_a_mag;
              r_rem <= '0;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_rem <= w_ge ? w_sub : w_shift[XLEN:0];
        end
        ST_END: begin
          r_ready  <= 1'b1;
          r_result <= r_sel_rem ? w_res_r : w_res_q;
          r_rd_out <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign ready_o   = r_ready;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_out;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit (directed vectors)
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          when;
  } exp_t;

  exp_t sb[$];

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 expected=0 result=%h rd=%0d", result_o, rd_addr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
        chk("latency_cycle", cyc, e.when);
      end
    end
  end

  // Issue one op; eo marks vectors that take the short path when early-out is built in.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit eo);
    exp_t e;
    int lat;
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
`ifdef DIV_EARLY_OUT_EN
    lat = eo ? 1 : 33;
`else
    lat = 33 + (eo ? 0 : 0);
`endif
    e.res = exp; e.rd = rd; e.when = cyc + 1 + lat;
    sb.push_back(e);
    #1 chk("busy_on_accept", 32'(busy_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 3'b000;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_addr_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    // Non-divide funct3 is ignored.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; dividend_i = 32'd9; divisor_i = 32'd3;
    #1 chk("busy_nondiv", 32'(busy_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    #1 chk("busy_after_nondiv", 32'(busy_o), 32'd0);

    // DIVU 100/7 with busy_o tracked through CALC and dropping in END.
    do_op(F3_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 1'b0);
    for (int i = 0; i < 32; i++) begin
      #1 chk("busy_calc", 32'(busy_o), 32'd1);
      @(negedge clk);
    end
    chk("busy_end", 32'(busy_o), 32'd0);
    drain();

    do_op(F3_REM,  32'hFFFF_FFF9, 32'd2,        5'd2,  32'hFFFF_FFFF, 1'b0);
    drain();
    do_op(F3_DIV,  32'hFFFF_FFF9, 32'd2,        5'd3,  32'hFFFF_FFFD, 1'b0);
    drain();
    do_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1'b0);
    drain();
    do_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 1'b0);
    drain();
    do_op(F3_DIVU, 32'd5,         32'd0,        5'd6,  32'hFFFF_FFFF, 1'b1);
    drain();
    do_op(F3_REMU, 32'd5,         32'd0,        5'd7,  32'd5,         1'b1);
    drain();
    do_op(F3_DIV,  32'hFFFF_FFF7, 32'd0,        5'd8,  32'hFFFF_FFFF, 1'b1);
    drain();
    do_op(F3_REM,  32'hFFFF_FFF7, 32'd0,        5'd9,  32'hFFFF_FFF7, 1'b1);
    drain();
    do_op(F3_REM,  32'hFFFF_FFFD, 32'd10,       5'd10, 32'hFFFF_FFFD, 1'b1);
    drain();
    do_op(F3_DIV,  32'hFFFF_FFFD, 32'd10,       5'd11, 32'd0,         1'b1);
    drain();
    do_op(F3_DIVU, 32'd3,         32'd10,       5'd12, 32'd0,         1'b1);
    drain();
    do_op(F3_DIV,  32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 1'b0);
    drain();
    do_op(F3_REM,  32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1,        1'b0);
    drain();
    do_op(F3_DIVU, 32'hFFFF_FFFF, 32'h10,       5'd15, 32'h0FFF_FFFF, 1'b0);
    drain();
    do_op(F3_REMU, 32'hFFFF_FFFF, 32'h10,       5'd16, 32'h0000_000F, 1'b0);
    drain();

    // Reset in the middle of CALC abandons the op without a ready pulse.
    @(negedge clk);
    start_i = 1'b1; op_i = F3_REMU; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd17;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    do_op(F3_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 1'b0);
    drain();

    // start_i held high: only IDLE cycles accept, one op every 34 cycles.
    @(negedge clk);
    start_i = 1'b1; op_i = F3_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3;
    begin
      int next_acc;
      exp_t e;
      next_acc = cyc + 1;
      for (int k = 0; k < 70; k++) begin
        rd_addr_i = 5'((cyc + 1) % 32);
        if (cyc + 1 == next_acc) begin
          e.res = 32'd333; e.rd = rd_addr_i; e.when = next_acc + 33;
          sb.push_back(e);
          next_acc += 34;
        end
        @(negedge clk);
      end
    end
    start_i = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
